traffic_ped_crossing_ctrl: RTL and testbench
============================================

Name: traffic_ped_crossing_ctrl

Overview:
- Moore FSM for a pedestrian-request road crossing. It drives one road signal head (red/yellow/green) and one pedestrian head (don't-walk/walk/clearance).
- The 30 s and 3 s durations come from external timer blocks as slow square waves. A rising edge on a timer input is one "expiry event".
- The block sits between the timer/clock-divider logic and the lamp drivers.

Parameters:
- MIN_GREEN_EVENTS, 1: number of timer_30s events the road must stay green before a pedestrian request is served (1..15).

Ports:
- clk_out  in  1  system clock (divided clock); all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- timer_30s  in  1  30 s timer square wave; each rising edge is a long-interval event
- timer_3s  in  1  3 s timer square wave; each rising edge is a short-interval event
- button  in  1  pedestrian request, level, sampled each clock
- traff_state  out  3  road head, one-hot: [2]=red, [1]=yellow, [0]=green
- pedes_state  out  2  pedestrian head: 2'b01 don't-walk, 2'b10 walk, 2'b11 clearance

Behaviour:
- Edge detection:
  - prev_30 and prev_3 registers hold the previous sample; both reset to 1, so a timer already high at reset release is not an event.
  - ev_30 = timer_30s & ~prev_30; ev_3 = timer_3s & ~prev_3.
  - Both are evaluated at the same clock edge that updates the state.
- Request latch req:
  - Set when button=1 at a clock edge in GREEN, YELLOW or RED_CLEAR.
  - Cleared on entry to RED_WALK.
  - Button is ignored in RED_WALK.
  - Reset value 0.
- Green counter gcnt, 4 bits:
  - Cleared on entry to GREEN.
  - Increments on ev_30 while in GREEN, saturating at MIN_GREEN_EVENTS.
- States and outputs (outputs decoded combinationally from the state register only):
  - GREEN: traff 3'b001, pedes 2'b01
  - YELLOW: traff 3'b010, pedes 2'b01
  - RED_WALK: traff 3'b100, pedes 2'b10
  - RED_CLEAR: traff 3'b100, pedes 2'b11
- Transitions:
  - GREEN -> YELLOW when req=1 and gcnt>=MIN_GREEN_EVENTS. Otherwise the block stays GREEN indefinitely.
  - YELLOW -> RED_WALK on ev_3.
  - RED_WALK -> RED_CLEAR on ev_30.
  - RED_CLEAR -> GREEN on ev_3.
  - Events in any other state are discarded and are not queued.
- Latency:
  - A button sampled high at edge N sets req at N. If gcnt is already satisfied, the state becomes YELLOW at edge N+1.
  - A timer rising edge sampled at edge N changes state at edge N.
- Simultaneous events: ev_30 and ev_3 on the same edge are each used only by the state that consumes them. At most one transition per cycle.
- Reset (any time, mid-sequence included):
  - State goes to GREEN immediately (traff 3'b001, pedes 2'b01).
  - req=0, gcnt=0, prev_30=prev_3=1.
- Safety invariants:
  - traff_state is always one-hot.
  - pedes_state is never 2'b10 or 2'b11 unless traff_state==3'b100.
  - pedes_state is never 2'b00.
  - An illegal state encoding recovers to GREEN on the next clock.

Optional Feature:
- Macro TRAFFIC_INPUT_SYNC_EN.
- Defined:
  - button, timer_30s and timer_3s each pass through a 2-flop synchronizer, reset to 0, 0, 0 respectively, before edge detection and the latch.
  - All input-to-state latencies grow by 2 clocks.
- Undefined:
  - Inputs are used directly as above.

Decomposition:
- Package traffic_pkg:
  - state enum {GREEN, YELLOW, RED_WALK, RED_CLEAR} in 2 bits.
  - Localparams TRAFF_GREEN/YELLOW/RED (3'b001/010/100) and PED_DONT_WALK/WALK/CLEAR (2'b01/10/11).
- One sub-module, rise_edge_det:
  - Ports clk, reset, in, pulse; reset value of prev is 1.
  - Instantiated for each timer.
  - It also hosts the optional synchronizer stages.

Test Plan:
1. Reset held, then released with button=0 and timers toggling (clk period 2 ns, timer_3s half-period 45 ns, timer_30s half-period 450 ns) -> output stays traff 3'b001 / pedes 2'b01 for the whole run.
2. Button pulsed for 1 cycle after the first timer_30s rise (MIN_GREEN_EVENTS=1) -> YELLOW 1 clock later. Next timer_3s rise gives traff 3'b100 / pedes 2'b10. Next timer_30s rise gives pedes 2'b11. Next timer_3s rise returns to 3'b001 / 2'b01.
3. Button pressed before any timer_30s rise -> stays GREEN until the first timer_30s rise, then YELLOW on the following clock.
4. Reset asserted during RED_WALK -> outputs become 3'b001 / 2'b01 asynchronously, before the next clock edge. req is cleared.
5. Button held high throughout RED_WALK -> no request remains after returning to GREEN. Button pressed in RED_CLEAR -> the next cycle is served.
6. Invariant assertions over a random button/timer run -> traff_state always one-hot; walk or clearance only while red.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and lamp encodings for the pedestrian crossing controller
//
// Purpose : controller state enum and the road/pedestrian lamp codes.
// Ports   : none (package).
package traffic_pkg;

   typedef enum logic [1:0] {
      GREEN     = 2'd0,
      YELLOW    = 2'd1,
      RED_WALK  = 2'd2,
      RED_CLEAR = 2'd3
   } state_e;

   localparam logic [2:0] TRAFF_GREEN  = 3'b001;
   localparam logic [2:0] TRAFF_YELLOW = 3'b010;
   localparam logic [2:0] TRAFF_RED    = 3'b100;

   localparam logic [1:0] PED_DONT_WALK = 2'b01;
   localparam logic [1:0] PED_WALK      = 2'b10;
   localparam logic [1:0] PED_CLEAR     = 2'b11;

endpackage

// File: rtl/traffic_ped_crossing_ctrl_rise_edge_det.sv
// rtl/traffic_ped_crossing_ctrl_rise_edge_det.sv - rising-edge detector for a slow timer square wave
//
// Purpose : one-clock pulse on each rising edge of in. When TRAFFIC_INPUT_SYNC_EN
//           is defined, in first passes through a 2-flop synchronizer (reset 0).
// Ports   : clk   in  system clock
//           reset in  asynchronous, active-high reset
//           in    in  timer square wave
//           pulse out one-clock pulse per rising edge of in
module rise_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic pulse
);

   logic in_s;

`ifdef TRAFFIC_INPUT_SYNC_EN
   logic [1:0] sync_q, sync_d;

   always_comb sync_d = {sync_q[0], in};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= 2'b00;
      else       sync_q <= sync_d;
   end

   assign in_s = sync_q[1];
`else
   assign in_s = in;
`endif

   logic prev_q, prev_d;

   always_comb prev_d = in_s;

   // prev resets high so a timer already high at reset release is not an event
   always_ff @(posedge clk or posedge reset) begin
      if (reset) prev_q <= 1'b1;
      else       prev_q <= prev_d;
   end

   assign pulse = in_s & ~prev_q;

endmodule

// File: rtl/traffic_ped_crossing_ctrl.sv
// rtl/traffic_ped_crossing_ctrl.sv - Moore FSM for a pedestrian-request road crossing
//
// Purpose : drives the road head and pedestrian head from a latched pedestrian
//           request and 30 s / 3 s timer expiry events. Optional macro
//           TRAFFIC_INPUT_SYNC_EN adds 2-flop synchronizers on all three inputs.
// Ports   : clk_out     in  system clock (divided)
//           reset       in  asynchronous, active-high reset
//           timer_30s   in  30 s timer square wave
//           timer_3s    in  3 s timer square wave
//           button      in  pedestrian request level
//           traff_state out road head one-hot {red, yellow, green}
//           pedes_state out pedestrian head (01 don't-walk, 10 walk, 11 clearance)
module traffic_ped_crossing_ctrl
   import traffic_pkg::*;
#(
   parameter int MIN_GREEN_EVENTS = 1
) (
   input  logic       clk_out,
   input  logic       reset,
   input  logic       timer_30s,
   input  logic       timer_3s,
   input  logic       button,
   output logic [2:0] traff_state,
   output logic [1:0] pedes_state
);

   localparam logic [3:0] MIN_G = 4'(MIN_GREEN_EVENTS);

   logic ev_30, ev_3, button_s;

   rise_edge_det u_det_30 (.clk(clk_out), .reset(reset), .in(timer_30s), .pulse(ev_30));
   rise_edge_det u_det_3  (.clk(clk_out), .reset(reset), .in(timer_3s),  .pulse(ev_3));

`ifdef TRAFFIC_INPUT_SYNC_EN
   logic [1:0] btn_sync_q, btn_sync_d;

   always_comb btn_sync_d = {btn_sync_q[0], button};

   always_ff @(posedge clk_out or posedge reset) begin
      if (reset) btn_sync_q <= 2'b00;
      else       btn_sync_q <= btn_sync_d;
   end

   assign button_s = btn_sync_q[1];
`else
   assign button_s = button;
`endif

   state_e     state_q, state_d;
   logic       req_q, req_d;
   logic [3:0] gcnt_q, gcnt_d;

   always_ff @(posedge clk_out or posedge reset) begin
      if (reset) begin
         state_q <= GREEN;
         req_q   <= 1'b0;
         gcnt_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         gcnt_q  <= gcnt_d;
      end
   end

   // Each state consumes only its own event; events seen elsewhere are dropped.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      gcnt_d  = gcnt_q;
      case (state_q)
         GREEN: begin
            if (button_s) req_d = 1'b1;
            if (ev_30 && (gcnt_q < MIN_G)) gcnt_d = gcnt_q + 4'd1;
            // uses the registered request, so a press is served one clock later
            if (req_q && (gcnt_q >= MIN_G)) state_d = YELLOW;
         end
         YELLOW: begin
            if (button_s) req_d = 1'b1;
            if (ev_3) begin
               state_d = RED_WALK;
               req_d   = 1'b0;
            end
         end
         RED_WALK: begin
            if (ev_30) state_d = RED_CLEAR;
         end
         RED_CLEAR: begin
            if (button_s) req_d = 1'b1;
            if (ev_3) begin
               state_d = GREEN;
               gcnt_d  = 4'd0;
            end
         end
         default: begin
            state_d = GREEN;
            gcnt_d  = 4'd0;
         end
      endcase
   end

   always_comb begin
      traff_state = TRAFF_GREEN;
      pedes_state = PED_DONT_WALK;
      case (state_q)
         GREEN:     begin traff_state = TRAFF_GREEN;  pedes_state = PED_DONT_WALK; end
         YELLOW:    begin traff_state = TRAFF_YELLOW; pedes_state = PED_DONT_WALK; end
         RED_WALK:  begin traff_state = TRAFF_RED;    pedes_state = PED_WALK;      end
         RED_CLEAR: begin traff_state = TRAFF_RED;    pedes_state = PED_CLEAR;     end
         default:   begin traff_state = TRAFF_GREEN;  pedes_state = PED_DONT_WALK; end
      endcase
   end

endmodule

// File: tb/tb_traffic_ped_crossing_ctrl.sv
// tb/tb_traffic_ped_crossing_ctrl.sv - self-checking bench for traffic_ped_crossing_ctrl
`timescale 1ns/10ps
module tb_traffic_ped_crossing_ctrl;

   localparam logic [2:0] T_G = 3'b001, T_Y = 3'b010, T_R = 3'b100;
   localparam logic [1:0] P_DW = 2'b01, P_W = 2'b10, P_C = 2'b11;
   localparam int MIN_EV = 1;

   logic       clk_out = 1'b0;
   logic       reset = 1'b1;
   logic       timer_30s = 1'b0;
   logic       timer_3s = 1'b0;
   logic       button = 1'b0;
   logic [2:0] traff_state;
   logic [1:0] pedes_state;

   traffic_ped_crossing_ctrl #(.MIN_GREEN_EVENTS(MIN_EV)) dut (
      .clk_out(clk_out), .reset(reset), .timer_30s(timer_30s), .timer_3s(timer_3s),
      .button(button), .traff_state(traff_state), .pedes_state(pedes_state)
   );

   always #1 clk_out = ~clk_out;

   typedef struct {
      logic [2:0] traff;
      logic [1:0] pedes;
      string      name;
   } exp_t;

   typedef struct {
      logic       b, t30, t3;
      logic [2:0] traff;
      logic [1:0] pedes;
   } vec_t;

   exp_t exp_q[$];
   vec_t tbl[34];
   int   n_tests = 0;
   int   n_fail  = 0;

   // reference model state for the random run (0 G, 1 Y, 2 RW, 3 RC)
   int   m_state, m_gcnt;
   logic m_req, m_p30, m_p3;

   function automatic vec_t mk(input logic b, t30, t3, input logic [2:0] tr, input logic [1:0] pd);
      vec_t v;
      v.b = b; v.t30 = t30; v.t3 = t3; v.traff = tr; v.pedes = pd;
      return v;
   endfunction

   task automatic check_out();
      exp_t e;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard: no expected entry queued");
         return;
      end
      e = exp_q.pop_front();
      if (traff_state !== e.traff || pedes_state !== e.pedes) begin
         n_fail++;
         $display("FAIL %s @%0t: got traff=%b pedes=%b, want traff=%b pedes=%b",
                  e.name, $time, traff_state, pedes_state, e.traff, e.pedes);
      end
      n_tests++;
      if (!$onehot(traff_state) || pedes_state == 2'b00 ||
          (pedes_state[1] && traff_state != T_R)) begin
         n_fail++;
         $display("FAIL invariant %s @%0t: got traff=%b pedes=%b, want one-hot road and walk/clear only on red",
                  e.name, $time, traff_state, pedes_state);
      end
   endtask

   task automatic step(input logic b, t30, t3, input logic [2:0] tr, input logic [1:0] pd,
                       input string nm);
      @(negedge clk_out);
      button = b; timer_30s = t30; timer_3s = t3;
      exp_q.push_back('{tr, pd, nm});
      @(posedge clk_out);
      #0.5;
      check_out();
   endtask

   task automatic do_reset(input logic t30, t3);
      @(negedge clk_out);
      reset = 1'b1; button = 1'b0; timer_30s = t30; timer_3s = t3;
      repeat (2) @(negedge clk_out);
      exp_q.push_back('{T_G, P_DW, "in_reset"});
      check_out();
      reset = 1'b0;
   endtask

   function automatic logic [2:0] m_traff(input int s);
      case (s)
         1:       return T_Y;
         2, 3:    return T_R;
         default: return T_G;
      endcase
   endfunction

   function automatic logic [1:0] m_pedes(input int s);
      case (s)
         2:       return P_W;
         3:       return P_C;
         default: return P_DW;
      endcase
   endfunction

   task automatic model_step(input logic b, t30, t3);
      logic e30, e3;
      int   ns, ng;
      logic nr;
      e30 = t30 && !m_p30;
      e3  = t3 && !m_p3;
      ns = m_state; ng = m_gcnt; nr = m_req;
      if (m_state == 0) begin
         if (b) nr = 1'b1;
         if (e30 && m_gcnt < MIN_EV) ng = m_gcnt + 1;
         if (m_req && m_gcnt >= MIN_EV) ns = 1;
      end else if (m_state == 1) begin
         if (b) nr = 1'b1;
         if (e3) begin ns = 2; nr = 1'b0; end
      end else if (m_state == 2) begin
         if (e30) ns = 3;
      end else begin
         if (b) nr = 1'b1;
         if (e3) begin ns = 0; ng = 0; end
      end
      m_state = ns; m_gcnt = ng; m_req = nr;
      m_p30 = t30; m_p3 = t3;
   endtask

   initial begin
      // full request cycle, early press, ignored presses, discarded and simultaneous events
      tbl[0]  = mk(0,0,0, T_G, P_DW);
      tbl[1]  = mk(1,0,0, T_G, P_DW);
      tbl[2]  = mk(0,0,0, T_G, P_DW);
      tbl[3]  = mk(0,1,0, T_G, P_DW);
      tbl[4]  = mk(0,1,0, T_Y, P_DW);
      tbl[5]  = mk(0,1,1, T_R, P_W);
      tbl[6]  = mk(1,0,1, T_R, P_W);
      tbl[7]  = mk(1,1,1, T_R, P_C);
      tbl[8]  = mk(0,1,1, T_R, P_C);
      tbl[9]  = mk(0,1,0, T_R, P_C);
      tbl[10] = mk(0,1,1, T_G, P_DW);
      tbl[11] = mk(0,0,1, T_G, P_DW);
      tbl[12] = mk(0,1,1, T_G, P_DW);
      tbl[13] = mk(0,1,1, T_G, P_DW);
      tbl[14] = mk(0,1,0, T_G, P_DW);
      tbl[15] = mk(1,1,0, T_G, P_DW);
      tbl[16] = mk(0,1,0, T_Y, P_DW);
      tbl[17] = mk(0,1,1, T_R, P_W);
      tbl[18] = mk(0,0,0, T_R, P_W);
      tbl[19] = mk(0,0,1, T_R, P_W);
      tbl[20] = mk(0,1,0, T_R, P_C);
      tbl[21] = mk(1,1,0, T_R, P_C);
      tbl[22] = mk(0,1,1, T_G, P_DW);
      tbl[23] = mk(0,0,1, T_G, P_DW);
      tbl[24] = mk(0,1,1, T_G, P_DW);
      tbl[25] = mk(0,1,1, T_Y, P_DW);
      tbl[26] = mk(0,0,0, T_Y, P_DW);
      tbl[27] = mk(0,1,0, T_Y, P_DW);
      tbl[28] = mk(0,1,1, T_R, P_W);
      tbl[29] = mk(0,0,0, T_R, P_W);
      tbl[30] = mk(0,1,1, T_R, P_C);
      tbl[31] = mk(0,1,1, T_R, P_C);
      tbl[32] = mk(0,1,0, T_R, P_C);
      tbl[33] = mk(0,1,1, T_G, P_DW);

      // free-running timers, no button: road stays green
      do_reset(1'b0, 1'b0);
      for (int k = 0; k < 1000; k++) begin
         int  t_ns;
         t_ns = 2 * k;
         step(1'b0, ((t_ns / 450) % 2) == 1, ((t_ns / 45) % 2) == 1, T_G, P_DW, "idle_green");
      end

      do_reset(1'b0, 1'b0);
      for (int i = 0; i < 34; i++) begin
         step(tbl[i].b, tbl[i].t30, tbl[i].t3, tbl[i].traff, tbl[i].pedes,
              $sformatf("vec%0d", i));
      end

      // reset clears a pending request; a timer high at reset release is no event
      step(1'b1, 1'b0, 1'b0, T_G, P_DW, "pre_reset_press");
      do_reset(1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, T_G, P_DW, "high_at_release_a");
      step(1'b0, 1'b1, 1'b0, T_G, P_DW, "high_at_release_b");
      step(1'b0, 1'b0, 1'b0, T_G, P_DW, "t30_low");
      step(1'b0, 1'b1, 1'b0, T_G, P_DW, "t30_rise_no_req");
      step(1'b0, 1'b1, 1'b0, T_G, P_DW, "req_cleared_by_reset");
      step(1'b1, 1'b1, 1'b0, T_G, P_DW, "press_served");
      step(1'b0, 1'b1, 1'b0, T_Y, P_DW, "yellow_next_clock");
      step(1'b0, 1'b1, 1'b1, T_R, P_W, "walk_before_reset");

      // asynchronous reset in RED_WALK, checked before the next clock edge
      @(posedge clk_out);
      #0.3;
      reset = 1'b1;
      #0.1;
      exp_q.push_back('{T_G, P_DW, "async_reset"});
      check_out();
      @(negedge clk_out);
      timer_30s = 1'b0; timer_3s = 1'b0;
      @(negedge clk_out);
      reset = 1'b0;
      step(1'b0, 1'b0, 1'b0, T_G, P_DW, "after_async_a");
      step(1'b0, 1'b1, 1'b0, T_G, P_DW, "after_async_b");
      step(1'b0, 1'b1, 1'b0, T_G, P_DW, "after_async_c");

      // random run against the reference model
      do_reset(1'b0, 1'b0);
      m_state = 0; m_gcnt = 0; m_req = 1'b0; m_p30 = 1'b1; m_p3 = 1'b1;
      begin
         logic b, t30, t3;
         t30 = 1'b0; t3 = 1'b0;
         for (int k = 0; k < 2500; k++) begin
            b = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) t30 = ~t30;
            if ($urandom_range(0, 3) == 0) t3 = ~t3;
            model_step(b, t30, t3);
            step(b, t30, t3, m_traff(m_state), m_pedes(m_state), $sformatf("rand%0d", k));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
